// File: rtl/sched_control_unit.sv
// Instruction decode and process-scheduling controller: registered control bundle, IO stall,
// quantum preemption and halt. Optional quantum counter enabled by defining QUANTUM_PREEMPT_EN.
module sched_control_unit #(
  parameter int OPCODE_W        = 6,
  parameter int QUANTUM_W       = 8,
  parameter int DEFAULT_QUANTUM = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 instr_valid,
  input  logic [OPCODE_W-1:0]  Opcode,
  input  logic                 io_valid,
  input  logic                 ctx_done,
  input  logic                 kernel_mode,
  input  logic [QUANTUM_W-1:0] quantum_in,
  output logic [23:0]          ctrl,
  output logic                 ctrl_valid,
  output logic                 stall,
  output logic                 preempt,
  output logic [QUANTUM_W-1:0] quantum_left,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_IO_WAIT = 2'd1,
    ST_SWITCH  = 2'd2,
    ST_HALTED  = 2'd3
  } state_t;

  localparam logic [QUANTUM_W-1:0] DEF_Q_C = QUANTUM_W'(DEFAULT_QUANTUM);
  localparam logic [QUANTUM_W-1:0] Q_ONE_C = QUANTUM_W'(1'b1);

  state_t      state_r;
  logic [23:0] ctrl_r;
  logic        ctrl_valid_r;
  logic        preempt_r;
  logic [23:0] decode_s;
  logic        accept_s;
  logic        expire_s;
  logic        pending_s;

  function automatic logic [23:0] decode_op(input logic [OPCODE_W-1:0] op);
    logic [23:0] c;
    c = 24'd0;
    if ((op >> 3'd6) != {OPCODE_W{1'b0}}) begin
      c = 24'd0;
    end else begin
      case (op[5:0])
        6'h00: begin c[1:0] = 2'd1; c[8] = 1'b1; c[12:10] = 3'd4; end
        6'h01: begin c[6:5] = 2'd1; c[7] = 1'b1; c[8] = 1'b1; end
        6'h02: begin c[7] = 1'b1; c[9] = 1'b1; end
        6'h03: begin c[7] = 1'b1; c[8] = 1'b1; end
        6'h04: begin c[7] = 1'b1; c[8] = 1'b1; c[12:10] = 3'd1; end
        6'h05: begin c[4] = 1'b1; c[12:10] = 3'd3; end
        6'h09: begin c[3:2] = 2'd1; end
        6'h0A: begin c[1:0] = 2'd2; c[3:2] = 2'd2; end
        6'h0B: begin c[1:0] = 2'd2; c[3:2] = 2'd1; c[6:5] = 2'd2; c[8] = 1'b1; end
        6'h0C: begin c[1:0] = 2'd3; c[6:5] = 2'd3; c[8] = 1'b1; c[15] = 1'b1; end
        6'h0D: begin c[14] = 1'b1; end
        6'h0E: begin c[17:16] = 2'd1; c[9] = 1'b1; end
        6'h0F: begin c[18] = 1'b1; end
        6'h10: begin c[19] = 1'b1; end
        6'h11: begin c[17:16] = 2'd2; c[9] = 1'b1; c[20] = 1'b1; end
        6'h12: begin c[1:0] = 2'd3; c[22] = 1'b1; end
        6'h13: begin c[23] = 1'b1; end
        6'h3E: begin c[21] = 1'b1; end
        6'h3F: begin c[13] = 1'b1; end
        default: c = 24'd0;
      endcase
    end
    return c;
  endfunction

  assign decode_s = decode_op(Opcode);
  assign accept_s = instr_valid & (state_r == ST_RUN);

`ifdef QUANTUM_PREEMPT_EN
  logic [QUANTUM_W-1:0] quantum_r;
  logic [QUANTUM_W-1:0] q_reload_r;
  logic                 pending_r;
  logic                 consume_s;

  assign consume_s = accept_s & ~kernel_mode & ~decode_s[23] & (quantum_r != '0);
  assign expire_s  = consume_s & (quantum_r == Q_ONE_C);
  assign pending_s = pending_r;

  // Quantum counter, reload value and the expiry-during-input pending flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      quantum_r  <= DEF_Q_C;
      q_reload_r <= DEF_Q_C;
      pending_r  <= 1'b0;
    end else begin
      if (state_r == ST_SWITCH && ctx_done) begin
        quantum_r <= q_reload_r;
      end else if (accept_s && decode_s[23]) begin
        quantum_r  <= (quantum_in == '0) ? Q_ONE_C : quantum_in;
        q_reload_r <= (quantum_in == '0) ? Q_ONE_C : quantum_in;
      end else if (consume_s) begin
        quantum_r <= quantum_r - Q_ONE_C;
      end
      if (state_r == ST_IO_WAIT && io_valid) begin
        pending_r <= 1'b0;
      end else if (expire_s && decode_s[15]) begin
        pending_r <= 1'b1;
      end
    end
  end

  assign quantum_left = quantum_r;
`else
  logic unused_s;
  assign unused_s     = ^{quantum_in, kernel_mode, DEF_Q_C, Q_ONE_C};
  assign expire_s     = 1'b0;
  assign pending_s    = 1'b0;
  assign quantum_left = '0;
`endif

  // Scheduling FSM with registered control bundle, issue flag and preempt pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_RUN;
      ctrl_r       <= 24'd0;
      ctrl_valid_r <= 1'b0;
      preempt_r    <= 1'b0;
    end else begin
      ctrl_valid_r <= 1'b0;
      preempt_r    <= 1'b0;
      case (state_r)
        ST_RUN: begin
          if (accept_s) begin
            ctrl_r <= decode_s;
            if (decode_s[13]) begin
              state_r <= ST_HALTED;
            end else if (decode_s[15]) begin
              state_r <= ST_IO_WAIT;
            end else if (decode_s[21] || expire_s) begin
              state_r      <= ST_SWITCH;
              preempt_r    <= 1'b1;
              ctrl_valid_r <= 1'b1;
            end else begin
              ctrl_valid_r <= 1'b1;
            end
          end
        end
        ST_IO_WAIT: begin
          // The held input decode issues once data arrives, even if a switch follows
          if (io_valid) begin
            ctrl_valid_r <= 1'b1;
            if (pending_s) begin
              state_r   <= ST_SWITCH;
              preempt_r <= 1'b1;
            end else begin
              state_r <= ST_RUN;
            end
          end
        end
        ST_SWITCH: begin
          if (ctx_done) begin
            state_r <= ST_RUN;
          end
        end
        ST_HALTED: state_r <= ST_HALTED;
        default:   state_r <= ST_RUN;
      endcase
    end
  end

  assign ctrl       = ctrl_r;
  assign ctrl_valid = ctrl_valid_r;
  assign preempt    = preempt_r;
  assign state      = state_r;
  assign stall      = (state_r != ST_RUN);

endmodule
